seg_scan_decoder: RTL

Receive-side monitor for the multiplexed 2-digit traffic-light display bus. It samples the six active-low digit-select lines and the seven segment lines, and reconstructs the displayed two-digit BCD countdown and the active light group (red/yellow/green). It sits on the board-test/readback path and feeds the supervisor or logic analyser. It also flags illegal select or segment patterns and a stalled display.

---
 rtl/traffic_disp_pkg.sv | 39 +++
 rtl/seg7_to_bcd.sv | 29 ++
 rtl/seg_scan_decoder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/traffic_disp_pkg.sv
// Shared encodings for the traffic-light display bus: light groups, segment codes, blank select.
package traffic_disp_pkg;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'd0,
    LIGHT_YELLOW = 2'd1,
    LIGHT_GREEN  = 2'd2,
    LIGHT_NONE   = 2'd3
  } light_e;

  // Segment order is {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam logic [5:0] SEL_BLANK = 6'b111111;

  typedef struct packed {
    logic       vld;
    light_e     grp;
    logic       tens_pos;
    logic [3:0] dig;
  } pend_t;

  // Maps an active-high one-hot select to its light group (p5/p4 red, p3/p2 yellow, p1/p0 green).
  function automatic light_e sel_group(input logic [5:0] sel_low);
    if (|sel_low[5:4])      return LIGHT_RED;
    else if (|sel_low[3:2]) return LIGHT_YELLOW;
    else                    return LIGHT_GREEN;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment to BCD decoder; zero latency, no flow control.
// Unrecognised patterns raise illegal and return bcd=0.
module seg7_to_bcd
  import traffic_disp_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       illegal
);

  always_comb begin
    bcd     = 4'd0;
    illegal = 1'b0;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the 2-digit countdown and light group from the scanned display bus.
// Digit accepted 2+STABLE_CYCLES-1 edges after it appears, frame one edge later; no backpressure.
module seg_scan_decoder
  import traffic_disp_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic [5:0] sel,
  output logic       frame_valid,
  output logic [1:0] light,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] value,
  output logic       sel_err,
  output logic       seg_err,
  output logic       stale
);

  localparam int SCW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  logic [6:0]     seg_m, seg_s, seg_p;
  logic [5:0]     sel_m, sel_s, sel_p;
  logic [SCW-1:0] stab_cnt;
  logic [TOW-1:0] stale_cnt;
  logic           same, accept, multi_sel, seg_bad, match, done;
  logic [5:0]     sel_low;
  logic [3:0]     dig;
  light_e         grp, light_q;
  logic           tens_pos;
  pend_t          pend;

  // Select flops idle at blank so reset never looks like an all-low select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m <= '0;
      seg_s <= '0;
      seg_p <= '0;
      sel_m <= SEL_BLANK;
      sel_s <= SEL_BLANK;
      sel_p <= SEL_BLANK;
    end else begin
      seg_m <= seg;
      seg_s <= seg_m;
      seg_p <= seg_s;
      sel_m <= sel;
      sel_s <= sel_m;
      sel_p <= sel_s;
    end
  end

  assign same = (seg_s == seg_p) && (sel_s == sel_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    stab_cnt <= '0;
    else if (!same)                                stab_cnt <= '0;
    else if (stab_cnt != SCW'(STABLE_CYCLES - 1))  stab_cnt <= stab_cnt + 1'b1;
  end

  // Fires in the cycle whose edge brings the counter to STABLE_CYCLES-1.
  assign accept    = same && (stab_cnt == SCW'(STABLE_CYCLES - 2)) && (sel_s != SEL_BLANK);
  assign sel_low   = ~sel_s;
  assign multi_sel = (sel_low & (sel_low - 6'd1)) != 6'd0;
  assign grp       = sel_group(sel_low);
  assign tens_pos  = sel_low[4] | sel_low[2] | sel_low[0];

  seg7_to_bcd u_seg7_to_bcd (
    .seg     (seg_s),
    .bcd     (dig),
    .illegal (seg_bad)
  );

  assign match = pend.vld && (pend.grp == grp) && (pend.tens_pos != tens_pos);
  assign done  = accept && !multi_sel && !seg_bad && match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= '{vld: 1'b0, grp: LIGHT_NONE, tens_pos: 1'b0, dig: 4'd0};
      frame_valid <= 1'b0;
      sel_err     <= 1'b0;
      seg_err     <= 1'b0;
      light_q     <= LIGHT_NONE;
      tens        <= 4'd0;
      ones        <= 4'd0;
    end else begin
      frame_valid <= 1'b0;
      sel_err     <= 1'b0;
      seg_err     <= 1'b0;
      if (accept) begin
        if (multi_sel) begin
          sel_err  <= 1'b1;
          pend.vld <= 1'b0;
        end else if (seg_bad) begin
          seg_err  <= 1'b1;
          pend.vld <= 1'b0;
        end else if (match) begin
          frame_valid <= 1'b1;
          light_q     <= grp;
          tens        <= tens_pos ? dig : pend.dig;
          ones        <= tens_pos ? pend.dig : dig;
          pend.vld    <= 1'b0;
        end else begin
          pend <= '{vld: 1'b1, grp: grp, tens_pos: tens_pos, dig: dig};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    stale_cnt <= '0;
    else if (done)                                 stale_cnt <= '0;
    else if (stale_cnt != TOW'(TIMEOUT_CYCLES))    stale_cnt <= stale_cnt + 1'b1;
  end

  assign stale = (stale_cnt == TOW'(TIMEOUT_CYCLES));
  assign light = light_q;
  assign value = 7'(tens) * 7'd10 + 7'(ones);

endmodule
